// File: rtl/shot_scheduler.sv
// Bullet pool for a paddle shooter: launches on frame start from a synchronised fire
// button, moves bullets upward once per frame and renders them on the raster.
module shot_scheduler #(
  parameter int          NSLOT        = 4,
  parameter int          BULLET_W     = 4,
  parameter int          BULLET_H     = 8,
  parameter int          BULLET_VEL   = 8,
  parameter int          COOLDOWN     = 8,
  parameter int          VRES         = 480,
  parameter int          PADDLE_H     = 8,
  parameter int          LAUNCH_Y     = VRES - PADDLE_H - BULLET_H,
  parameter logic [23:0] BULLET_COLOR = 24'hFFFF00
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  input  logic                    fsync,
  input  logic signed [11:0]      hpos,
  input  logic signed [11:0]      vpos,
  input  logic                    fire,
  input  logic                    game_en,
  input  logic [11:0]             paddle_center_x,
  input  logic [NSLOT-1:0]        hit_clr,
  output logic [NSLOT-1:0]        slot_valid,
  output logic [NSLOT-1:0]        slot_hit,
  output logic                    active,
  output logic [2:0][7:0]         pixel,
  output logic [7:0]              shot_count
);

  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic signed [11:0] VEL_S    = 12'(BULLET_VEL);
  localparam logic signed [11:0] LAUNCH_S = 12'(LAUNCH_Y);
  localparam logic [11:0]        HALF_W   = 12'(BULLET_W / 2);
  localparam logic signed [13:0] W_M1     = 14'(BULLET_W - 1);
  localparam logic signed [13:0] H_M1     = 14'(BULLET_H - 1);

  typedef enum logic {FREE = 1'b0, FLYING = 1'b1} slot_state_t;

  slot_state_t              state_q [NSLOT];
  slot_state_t              state_d [NSLOT];
  logic [11:0]              x_q     [NSLOT];
  logic [11:0]              x_d     [NSLOT];
  logic signed [11:0]       ytop_q  [NSLOT];
  logic signed [11:0]       ytop_d  [NSLOT];

  logic [2:0]      fire_sync;
  logic            fire_req;
  logic [CD_W-1:0] cooldown;
  logic [NSLOT-1:0] launch_sel;
  logic            slot_found;
  logic            launch;
  logic [11:0]     launch_x;

  // Lowest-index FREE slot that is not being killed this cycle.
  always_comb begin
    launch_sel = '0;
    slot_found = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      if (!slot_found && state_q[i] == FREE && !hit_clr[i]) begin
        launch_sel[i] = 1'b1;
        slot_found    = 1'b1;
      end
    end
    launch   = fsync && fire_req && (cooldown == '0) && game_en && slot_found;
    launch_x = (paddle_center_x < HALF_W) ? 12'd0 : paddle_center_x - HALF_W;
  end

  // Kill beats everything; a slot launched this fsync was FREE, so it never also moves.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      state_d[i] = state_q[i];
      x_d[i]     = x_q[i];
      ytop_d[i]  = ytop_q[i];
      if (hit_clr[i] || !game_en) begin
        state_d[i] = FREE;
      end else if (fsync) begin
        if (state_q[i] == FLYING) begin
          if (ytop_q[i] < VEL_S) state_d[i] = FREE;
          else                   ytop_d[i]  = ytop_q[i] - VEL_S;
        end else if (launch && launch_sel[i]) begin
          state_d[i] = FLYING;
          x_d[i]     = launch_x;
          ytop_d[i]  = LAUNCH_S;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      for (int i = 0; i < NSLOT; i++) begin
        state_q[i] <= FREE;
        x_q[i]     <= '0;
        ytop_q[i]  <= '0;
      end
      fire_sync  <= '0;
      fire_req   <= 1'b0;
      cooldown   <= '0;
      shot_count <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        state_q[i] <= state_d[i];
        x_q[i]     <= x_d[i];
        ytop_q[i]  <= ytop_d[i];
      end
      fire_sync <= {fire_sync[1:0], fire};
      if (fsync)                          fire_req <= 1'b0;
      else if (fire_sync[2] && game_en)   fire_req <= 1'b1;
      if (fsync && game_en) begin
        if (launch)                cooldown <= CD_W'(COOLDOWN);
        else if (cooldown != '0)   cooldown <= cooldown - 1'b1;
      end
      if (launch) shot_count <= shot_count + 8'd1;
    end
  end

  logic signed [13:0] hp14, vp14;
  assign hp14 = $signed({{2{hpos[11]}}, hpos});
  assign vp14 = $signed({{2{vpos[11]}}, vpos});

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    logic signed [13:0] xl, yt;
    assign xl            = $signed({2'b00, x_q[g]});
    assign yt            = $signed({{2{ytop_q[g][11]}}, ytop_q[g]});
    assign slot_valid[g] = (state_q[g] == FLYING);
    assign slot_hit[g]   = slot_valid[g] && (hp14 >= xl) && (hp14 <= xl + W_M1)
                           && (vp14 >= yt) && (vp14 <= yt + H_M1);
  end

  assign active = |slot_hit;
  assign pixel  = active ? BULLET_COLOR : 24'h000000;

endmodule

// File: tb/tb_shot_scheduler.sv
// Randomised bench for shot_scheduler: a frame-level reference model predicts the
// visible outputs each cycle; a monitor compares them mid-cycle.
module tb_shot_scheduler;
  localparam int NSLOT = 4, W = 4, H = 8, VEL = 8, CD = 8, LY = 480 - 8 - 8;
  localparam int OUT_W = 2 * NSLOT + 1 + 24 + 8;

  logic              pixel_clk = 1'b0;
  logic              rst = 1'b1, fsync = 1'b0, fire = 1'b0, game_en = 1'b0;
  logic signed [11:0] hpos = '0, vpos = '0;
  logic [11:0]       paddle_center_x = '0;
  logic [NSLOT-1:0]  hit_clr = '0, slot_valid, slot_hit;
  logic              active;
  logic [2:0][7:0]   pixel;
  logic [7:0]        shot_count;

  shot_scheduler dut (
    .pixel_clk(pixel_clk), .rst(rst), .fsync(fsync), .hpos(hpos), .vpos(vpos),
    .fire(fire), .game_en(game_en), .paddle_center_x(paddle_center_x),
    .hit_clr(hit_clr), .slot_valid(slot_valid), .slot_hit(slot_hit),
    .active(active), .pixel(pixel), .shot_count(shot_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Reference model state: what the game world looks like, frame by frame.
  bit m_fly [NSLOT];
  int m_x   [NSLOT];
  int m_y   [NSLOT];
  int m_cd = 0, m_count = 0;
  bit m_req = 0;
  bit [2:0] m_fire_hist = '0;

  logic [OUT_W-1:0] exp_q[$];
  int checks = 0, errors = 0, cyc = 0;

  function automatic logic [OUT_W-1:0] expect_out(input int hp, input int vp);
    logic [NSLOT-1:0] sv, sh;
    logic any;
    for (int i = 0; i < NSLOT; i++) begin
      sv[i] = m_fly[i];
      sh[i] = m_fly[i] && hp >= m_x[i] && hp <= m_x[i] + W - 1
              && vp >= m_y[i] && vp <= m_y[i] + H - 1;
    end
    any = |sh;
    return {sv, sh, any, (any ? 24'hFFFF00 : 24'h000000), 8'(m_count)};
  endfunction

  function automatic void model_update(input logic r, fs, f, ge,
                                       input logic [11:0] pcx, input logic [NSLOT-1:0] hc);
    int sel;
    bit fire_seen;
    if (r) begin
      for (int i = 0; i < NSLOT; i++) begin m_fly[i] = 0; m_x[i] = 0; m_y[i] = 0; end
      m_cd = 0; m_count = 0; m_req = 0; m_fire_hist = '0;
      return;
    end
    fire_seen   = m_fire_hist[2];
    m_fire_hist = {m_fire_hist[1:0], f};
    sel = -1;
    if (fs && m_req && m_cd == 0 && ge)
      for (int i = 0; i < NSLOT; i++)
        if (sel < 0 && !m_fly[i] && !hc[i]) sel = i;
    for (int i = 0; i < NSLOT; i++) begin
      if (hc[i] || !ge) m_fly[i] = 0;
      else if (fs) begin
        if (m_fly[i]) begin
          if (m_y[i] < VEL) m_fly[i] = 0;
          else m_y[i] = m_y[i] - VEL;
        end else if (i == sel) begin
          m_fly[i] = 1;
          m_y[i]   = LY;
          m_x[i]   = (int'(pcx) < W / 2) ? 0 : int'(pcx) - W / 2;
        end
      end
    end
    if (ge && fs) begin
      if (sel >= 0) m_cd = CD;
      else if (m_cd > 0) m_cd = m_cd - 1;
    end
    if (sel >= 0) m_count = (m_count + 1) % 256;
    if (fs) m_req = 0;
    else if (fire_seen && ge) m_req = 1;
  endfunction

  // Monitor: outputs are compared at the falling edge against the oldest prediction.
  initial begin
    logic [OUT_W-1:0] exp_v, act_v;
    forever begin
      @(negedge pixel_clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {slot_valid, slot_hit, active, pixel, shot_count};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL outputs cycle %0d: got valid=%b hit=%b act=%b pix=%h cnt=%0d, expected valid=%b hit=%b act=%b pix=%h cnt=%0d",
                   cyc, act_v[OUT_W-1 -: NSLOT], act_v[OUT_W-1-NSLOT -: NSLOT], act_v[32], act_v[31:8], act_v[7:0],
                   exp_v[OUT_W-1 -: NSLOT], exp_v[OUT_W-1-NSLOT -: NSLOT], exp_v[32], exp_v[31:8], exp_v[7:0]);
        end
      end
    end
  end

  task automatic step(input logic r, fs, f, ge, input logic [11:0] pcx,
                      input logic [NSLOT-1:0] hc, input logic signed [11:0] hp, vp);
    rst = r; fsync = fs; fire = f; game_en = ge; paddle_center_x = pcx;
    hit_clr = hc; hpos = hp; vpos = vp;
    exp_q.push_back(expect_out(int'(hp), int'(vp)));
    @(posedge pixel_clk);
    model_update(r, fs, f, ge, pcx, hc);
    cyc++;
    #1;
  endtask

  // Aim the raster at (or just beside) a live bullet most of the time.
  task automatic pick(output logic signed [11:0] hp, vp);
    int i;
    i = $urandom_range(0, NSLOT - 1);
    if (m_fly[i] && $urandom_range(0, 3) != 0) begin
      hp = 12'(m_x[i] - 1 + $urandom_range(0, W + 1));
      vp = 12'(m_y[i] - 1 + $urandom_range(0, H + 1));
    end else begin
      hp = 12'($urandom_range(0, 720) - 20);
      vp = 12'($urandom_range(0, 520) - 20);
    end
  endtask

  task automatic frame(input logic f, ge, input logic [11:0] pcx, input int len,
                       input logic [NSLOT-1:0] hc_fs, input bit rand_kill);
    logic signed [11:0] hp, vp;
    logic [NSLOT-1:0] hc;
    for (int c = 0; c < len; c++) begin
      pick(hp, vp);
      hc = (c == 0) ? hc_fs : '0;
      if (rand_kill && $urandom_range(0, 40) == 0) hc = 4'(1 << $urandom_range(0, NSLOT - 1));
      step(1'b0, c == 0, f, ge, pcx, hc, hp, vp);
    end
  endtask

  initial begin
    @(posedge pixel_clk);
    model_update(1'b1, 0, 0, 0, '0, '0);
    #1;
    step(1'b1, 1'b1, 1'b1, 1'b1, 12'd320, 4'b1111, 12'sd0, 12'sd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 12'd320, '0, 12'sd0, 12'sd0);
    repeat (2) frame(0, 1, 12'd320, 6, '0, 0);
    frame(1, 1, 12'd320, 6, '0, 0);
    repeat (3) frame(0, 1, 12'd320, 6, '0, 0);
    repeat (20) frame(1, 1, 12'd200, 5, '0, 0);
    frame(0, 1, 12'd200, 5, 4'b0001, 0);
    repeat (12) frame(1, 1, 12'd1, 5, '0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 12'd50, 4'b0010, 12'sd0, 12'sd0);
    repeat (12) frame(1, 1, 12'd0, 5, '0, 0);
    repeat (3) frame(1, 0, 12'd100, 5, '0, 0);
    repeat (300) begin
      if ($urandom_range(0, 99) == 0) step(1'b1, 1'b0, 1'b0, 1'b1, '0, '0, 12'sd0, 12'sd0);
      frame($urandom_range(0, 1), $urandom_range(0, 19) != 0,
            12'($urandom_range(0, 5) == 0 ? $urandom_range(0, 3) : $urandom_range(0, 640)),
            $urandom_range(4, 8), 4'($urandom_range(0, 9) == 0 ? $urandom_range(1, 15) : 0), 1);
    end
    @(negedge pixel_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shot_scheduler.md
SHOT_SCHEDULER -- requirements
Module: shot_scheduler

Interface
REQ-001 Parameters: NSLOT, default 4, number of bullet slots.
REQ-002 Parameters: BULLET_W, default 4, bullet width in pixels.
REQ-003 Parameters: BULLET_H, default 8, bullet height in pixels.
REQ-004 Parameters: BULLET_VEL, default 8, upward pixels per frame.
REQ-005 Parameters: COOLDOWN, default 8, frames of launch lockout after a launch.
REQ-006 Parameters: LAUNCH_Y, default VRES-PADDLE_H-BULLET_H, launch top row.
REQ-007 Parameters: BULLET_COLOR, default 24'hFFFF00, RGB888.
REQ-008 Port: pixel_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-009 Port: rst, input, 1, synchronous active-high reset.
REQ-010 Port: fsync, input, 1, one-cycle frame-start strobe.
REQ-011 Port: hpos, input, signed 12, current scan x.
REQ-012 Port: vpos, input, signed 12, current scan y.
REQ-013 Port: fire, input, 1, raw asynchronous fire button.
REQ-014 Port: game_en, input, 1, launching and flight permitted when high.
REQ-015 Port: paddle_center_x, input, 12, paddle centre x from the paddle block.
REQ-016 Port: hit_clr, input, NSLOT, one-hot-or-multi slot kill requests from collision logic.
REQ-017 Port: slot_valid, output, NSLOT, per-slot FLYING flag.
REQ-018 Port: slot_hit, output, NSLOT, per-slot combinational overlap with (hpos,vpos).
REQ-019 Port: active, output, 1, OR of slot_hit.
REQ-020 Port: pixel, output, 8 x [0:2], [2]=R [1]=G [0]=B; BULLET_COLOR when active, else 0.
REQ-021 Port: shot_count, output, 8, launches since reset, wraps 255->0.

Function
REQ-022 fire SHALL pass a 3-flop synchroniser; only the third stage is used.
REQ-023 fire_req latch SHALL set on any non-fsync cycle with synced fire high and game_en high, and clear on every fsync.
REQ-024 Each slot SHALL be a 2-state FSM: FREE, FLYING; each holds x (12b) and ytop (signed 12b).
REQ-025 Launch at fsync SHALL occur iff fire_req=1, cooldown=0 (pre-update value), game_en=1, and an eligible slot exists (FREE and its hit_clr bit low).
REQ-026 Launch SHALL take the lowest-index eligible slot: FREE->FLYING, ytop<=LAUNCH_Y, x<=paddle_center_x-BULLET_W/2, clamped to 0 when paddle_center_x<BULLET_W/2.
REQ-027 On launch, cooldown SHALL load COOLDOWN and shot_count SHALL increment.
REQ-028 Otherwise, at each fsync with cooldown>0, cooldown SHALL decrement by 1.
REQ-029 Result: minimum launch spacing SHALL be COOLDOWN+1 frames.
REQ-030 With no eligible slot, the request SHALL be dropped; cooldown and count SHALL be unchanged.
REQ-031 At fsync, each slot FLYING before that fsync SHALL either move (ytop<=ytop-BULLET_VEL) or, if ytop<BULLET_VEL, go FREE.
REQ-032 A slot launched on a given fsync SHALL NOT move on that fsync.
REQ-033 hit_clr[i]=1 on any cycle SHALL force slot i FREE on the next edge, with priority over move and launch.
REQ-034 game_en=0 SHALL free all slots on the next edge and freeze cooldown; shot_count is held.
REQ-035 slot_hit[i] SHALL be 1 iff slot i is FLYING, x<=hpos<=x+BULLET_W-1, and ytop<=vpos<=ytop+BULLET_H-1, using signed compare.
REQ-036 slot_hit, active and pixel SHALL be purely combinational from current state and hpos/vpos, with zero latency.

Reset
REQ-037 On rst, all slots SHALL be FREE, x=0, ytop=0.
REQ-038 On rst, cooldown=0, fire_req=0, shot_count=0, and synchroniser flops=0.
REQ-039 Outputs after reset: slot_valid=0, active=0, pixel=0.
REQ-040 rst asserted mid-flight SHALL override fsync, hit_clr and launch in the same cycle.

Verification
REQ-041 Single shot: fire held 1 frame, paddle_center_x=320 -> next fsync slot0 FLYING, x=318, ytop=LAUNCH_Y, shot_count=1; next fsync ytop=LAUNCH_Y-8.
REQ-042 Cooldown: fire held continuously -> launches on fsyncs k, k+9, k+18; shot_count 1,2,3; slots 0,1,2.
REQ-043 Pool full: COOLDOWN=0, 5 consecutive fire frames -> slots 0-3 FLYING, 5th request dropped, shot_count=4; hit_clr=4'b0010 -> slot1 FREE next edge; next fire fills slot1.
REQ-044 Exit top: ytop=5 at fsync -> slot FREE, no move; ytop=8 -> ytop=0 and still FLYING.
REQ-045 Collision/raster: bullet at x=100, ytop=200; hpos=103, vpos=207 -> slot_hit=1 and pixel={FF,FF,00}; hpos=104 -> 0; hit_clr with fsync on the same cycle -> FREE, not moved.
REQ-046 Edge/reset: paddle_center_x=1 -> x=0; rst pulse mid-flight -> all outputs zero the next cycle; game_en=0 -> all slots freed and no launch.
